// File: rtl/pio_pkg.sv
// Shared constants and types for the LED output PIO.
// Register map addresses and the pulse FSM state encoding.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE    = 3'd3;
  localparam logic [2:0] ADDR_PULSE     = 3'd4;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/led_out_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// The CPU side is the master; the PIO is the slave.
interface led_out_pio_if #(
  parameter int DATA_WIDTH = 18
);

  logic [2:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/pio_pulse_timer.sv
// One-shot pulse timer: holds the inversion mask for max(len,1) cycles.
// mask_nxt exposes the next-cycle mask so the output register stays aligned.
module pio_pulse_timer
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [CNT_WIDTH-1:0]  len,
  output logic [DATA_WIDTH-1:0] active_mask,
  output logic [DATA_WIDTH-1:0] mask_nxt,
  output logic                  busy
);

  pulse_state_t          state_q;
  pulse_state_t          state_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [DATA_WIDTH-1:0] mask_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      active_mask <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_mask <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = active_mask;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PULSE;
          mask_d  = mask;
          // zero length is treated as a single cycle
          cnt_d   = (len == '0) ? '0 : len - CNT_WIDTH'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          mask_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase
  end

  assign busy     = (state_q == PULSE);
  assign mask_nxt = mask_d;

endmodule

// File: rtl/led_out_pio.sv
// Avalon-MM output PIO with set/clear/toggle and a timed one-shot pulse.
// out_port is registered from the next data and mask values.
module led_out_pio
  import pio_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 18,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter int                    PULSE_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  led_out_pio_if.slave          bus,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic                       wr;
  logic                       start;
  logic                       busy;
  logic [DATA_WIDTH-1:0]      data_reg;
  logic [DATA_WIDTH-1:0]      data_nxt;
  logic [DATA_WIDTH-1:0]      mask_q;
  logic [DATA_WIDTH-1:0]      mask_nxt;
  logic [DATA_WIDTH-1:0]      rd_mux;
  logic [PULSE_CNT_WIDTH-1:0] pulse_len;

  assign wr    = bus.chipselect & ~bus.write_n;
  assign start = wr && (bus.address == ADDR_PULSE);

  always_comb begin
    data_nxt = data_reg;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:   data_nxt = bus.writedata;
        ADDR_SET:    data_nxt = data_reg | bus.writedata;
        ADDR_CLEAR:  data_nxt = data_reg & ~bus.writedata;
        ADDR_TOGGLE: data_nxt = data_reg ^ bus.writedata;
        default:     data_nxt = data_reg;
      endcase
    end
  end

  pio_pulse_timer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (PULSE_CNT_WIDTH)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mask        (bus.writedata),
    .len         (pulse_len),
    .active_mask (mask_q),
    .mask_nxt    (mask_nxt),
    .busy        (busy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg  <= RESET_VALUE;
      out_port  <= RESET_VALUE;
      pulse_len <= PULSE_CNT_WIDTH'(1);
    end else begin
      data_reg <= data_nxt;
      out_port <= data_nxt ^ mask_nxt;
      if (wr && (bus.address == ADDR_PULSE_LEN))
        pulse_len <= PULSE_CNT_WIDTH'(bus.writedata);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:      rd_mux = data_reg;
      ADDR_PULSE:     rd_mux = mask_q;
      ADDR_PULSE_LEN: rd_mux = DATA_WIDTH'(pulse_len);
      ADDR_STATUS:    rd_mux[0] = busy;
      default:        rd_mux = '0;
    endcase
  end

  // read path ignores chipselect; one cycle of latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= rd_mux;
  end

endmodule
